interval_timer: RTL and testbench



---
 rtl/traffic_pkg.sv | 24 ++
 rtl/tick_divider.sv | 29 ++
 rtl/interval_timer.sv | 82 ++++++++
 tb/tb_interval_timer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light controller and its interval timer.
// Selector codes, light outputs and controller state names.
package traffic_pkg;

  localparam logic [1:0] BASE_SELECT = 2'd0;
  localparam logic [1:0] EXT_SELECT  = 2'd1;
  localparam logic [1:0] YEL_SELECT  = 2'd2;
  localparam logic [1:0] ZERO_SELECT = 2'd3;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_t;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_EXT    = 3'd1,
    MAIN_YELLOW = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4
  } traffic_state_t;

endpackage

// File: rtl/tick_divider.sv
// One-second strobe generator: free-running modulo-DIV_COUNT counter.
// clear restarts the count so a fresh interval gets a full first second.
module tick_divider #(
  parameter int DIV_COUNT = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_COUNT - 1);

  logic [CW-1:0] divCount;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      divCount <= '0;
    end else if (divCount == LAST) begin
      divCount <= '0;
    end else begin
      divCount <= divCount + CW'(1);
    end
  end

  assign tick = (divCount == LAST);

endmodule

// File: rtl/interval_timer.sv
// Programmable seconds-interval timer sequencing the traffic-light FSM.
// Loads a selected interval on start and pulses expired when it runs out.
module interval_timer
  import traffic_pkg::*;
#(
  parameter int DIV_COUNT    = 100000000,
  parameter int VAL_W        = 4,
  parameter int BASE_DEFAULT = 6,
  parameter int EXT_DEFAULT  = 3,
  parameter int YEL_DEFAULT  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_timer,
  input  logic [1:0]       time_param,
  input  logic             prog_sync,
  input  logic [1:0]       prog_sel,
  input  logic [VAL_W-1:0] prog_value,
  output logic             expired,
  output logic             busy,
  output logic [VAL_W-1:0] remaining,
  output logic             tick
);

  logic [VAL_W-1:0] baseVal;
  logic [VAL_W-1:0] extVal;
  logic [VAL_W-1:0] yelVal;
  logic [VAL_W-1:0] selVal;

  tick_divider #(
    .DIV_COUNT(DIV_COUNT)
  ) uDivider (
    .clk  (clk),
    .reset(reset),
    .clear(start_timer),
    .tick (tick)
  );

  always_comb begin
    selVal = '0;
    unique case (1'b1)
      (time_param == BASE_SELECT): selVal = baseVal;
      (time_param == EXT_SELECT):  selVal = extVal;
      (time_param == YEL_SELECT):  selVal = yelVal;
      default:                     selVal = '0;
    endcase
  end

  // Start has priority over the terminal tick, so a restart never expires.
  always_ff @(posedge clk) begin
    if (reset) begin
      baseVal   <= VAL_W'(BASE_DEFAULT);
      extVal    <= VAL_W'(EXT_DEFAULT);
      yelVal    <= VAL_W'(YEL_DEFAULT);
      remaining <= '0;
      busy      <= 1'b0;
      expired   <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (prog_sync) begin
        case (prog_sel)
          BASE_SELECT: baseVal <= prog_value;
          EXT_SELECT:  extVal  <= prog_value;
          YEL_SELECT:  yelVal  <= prog_value;
          default:     ;
        endcase
      end
      if (start_timer) begin
        remaining <= selVal;
        busy      <= (selVal != '0);
        expired   <= (selVal == '0);
      end else if (tick && busy) begin
        remaining <= remaining - VAL_W'(1);
        if (remaining == VAL_W'(1)) begin
          busy    <= 1'b0;
          expired <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer with DIV_COUNT=4.
// Directed scenarios plus a randomized run against an arithmetic model.
module tb_interval_timer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_timer = 1'b0;
  logic [1:0] time_param = 2'd0;
  logic       prog_sync = 1'b0;
  logic [1:0] prog_sel = 2'd0;
  logic [3:0] prog_value = 4'd0;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;
  logic       tick;

  int nCmp = 0;
  int nBad = 0;

  // reference model state
  int mReg[3];
  bit mRun = 0;
  int mVal = 0;
  int mStart = 0;
  int mClr = 0;
  int mEdge = 0;
  bit mExp = 0;

  interval_timer #(
    .DIV_COUNT(DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_timer(start_timer),
    .time_param (time_param),
    .prog_sync  (prog_sync),
    .prog_sel   (prog_sel),
    .prog_value (prog_value),
    .expired    (expired),
    .busy       (busy),
    .remaining  (remaining),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  function automatic int mRem();
    return mRun ? mVal - (mEdge - mStart) / DIV : 0;
  endfunction

  function automatic bit mTick();
    return ((mEdge - mClr) % DIV) == DIV - 1;
  endfunction

  task automatic modelEdge();
    int v;
    mEdge++;
    if (reset) begin
      mReg = '{6, 3, 2};
      mRun = 0;
      mExp = 0;
      mClr = mEdge;
      return;
    end
    mExp = 0;
    if (start_timer) begin
      v = (time_param == 2'd3) ? 0 : mReg[time_param];
      mClr = mEdge;
      if (v == 0) begin
        mRun = 0;
        mExp = 1;
      end else begin
        mRun = 1;
        mVal = v;
        mStart = mEdge;
      end
    end else if (mRun && (mEdge - mStart) == mVal * DIV) begin
      mRun = 0;
      mExp = 1;
    end
    if (prog_sync && prog_sel != 2'd3) mReg[prog_sel] = prog_value;
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    reset = 1'b0;
    start_timer = 1'b0;
    prog_sync = 1'b0;
  endtask

  task automatic startT(input logic [1:0] tp);
    time_param = tp;
    start_timer = 1'b1;
    step();
  endtask

  task automatic runFor(input int limit, output int firstK, output int pulses);
    firstK = -1;
    pulses = 0;
    for (int k = 1; k <= limit; k++) begin
      step();
      if (expired === 1'b1) begin
        pulses++;
        if (firstK < 0) firstK = k;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b1;
    step();
    nCmp++;
    if (busy !== 1'b0) begin
      nBad++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    nCmp++;
    if (remaining !== 4'd0) begin
      nBad++; $display("FAIL reset_remaining: got %0d want 0", remaining);
    end
    nCmp++;
    if (expired !== 1'b0) begin
      nBad++; $display("FAIL reset_expired: got %b want 0", expired);
    end
    nCmp++;
    if (tick !== 1'b0) begin
      nBad++; $display("FAIL reset_tick: got %b want 0", tick);
    end
  endtask

  task automatic test_base();
    int k, p;
    startT(2'd0);
    nCmp++;
    if (busy !== 1'b1 || remaining !== 4'd6) begin
      nBad++;
      $display("FAIL base_load: got busy=%b rem=%0d want busy=1 rem=6", busy, remaining);
    end
    runFor(30, k, p);
    nCmp++;
    if (k != 24 || p != 1) begin
      nBad++;
      $display("FAIL base_latency: got at=%0d pulses=%0d want at=24 pulses=1", k, p);
    end
    nCmp++;
    if (busy !== 1'b0 || remaining !== 4'd0) begin
      nBad++;
      $display("FAIL base_after: got busy=%b rem=%0d want 0/0", busy, remaining);
    end
  endtask

  task automatic test_zero();
    int k, p;
    startT(2'd3);
    nCmp++;
    if (expired !== 1'b1 || busy !== 1'b0) begin
      nBad++;
      $display("FAIL zero_pulse: got exp=%b busy=%b want 1/0", expired, busy);
    end
    runFor(12, k, p);
    nCmp++;
    if (p != 0 || busy !== 1'b0) begin
      nBad++;
      $display("FAIL zero_after: got pulses=%0d busy=%b want 0/0", p, busy);
    end
  endtask

  task automatic test_prog_ext();
    int k, p;
    prog_sync = 1'b1; prog_sel = 2'd1; prog_value = 4'd5;
    step();
    startT(2'd1);
    nCmp++;
    if (remaining !== 4'd5) begin
      nBad++; $display("FAIL ext_load: got %0d want 5", remaining);
    end
    runFor(24, k, p);
    nCmp++;
    if (k != 20 || p != 1) begin
      nBad++;
      $display("FAIL ext_latency: got at=%0d pulses=%0d want at=20 pulses=1", k, p);
    end
    prog_sync = 1'b1; prog_sel = 2'd3; prog_value = 4'd9;
    step();
    startT(2'd1);
    nCmp++;
    if (remaining !== 4'd5) begin
      nBad++; $display("FAIL sel3_ext: got %0d want 5", remaining);
    end
    startT(2'd0);
    nCmp++;
    if (remaining !== 4'd6) begin
      nBad++; $display("FAIL sel3_base: got %0d want 6", remaining);
    end
    startT(2'd2);
    nCmp++;
    if (remaining !== 4'd2) begin
      nBad++; $display("FAIL sel3_yel: got %0d want 2", remaining);
    end
    runFor(10, k, p);
    nCmp++;
    if (k != 8 || p != 1) begin
      nBad++;
      $display("FAIL yel_latency: got at=%0d pulses=%0d want at=8 pulses=1", k, p);
    end
  endtask

  task automatic test_restart();
    int k, p;
    startT(2'd2);
    runFor(4, k, p);
    startT(2'd0);
    runFor(30, k, p);
    nCmp++;
    if (k != 24 || p != 1) begin
      nBad++;
      $display("FAIL restart: got at=%0d pulses=%0d want at=24 pulses=1", k, p);
    end
  endtask

  task automatic test_terminal_start();
    int k, p;
    startT(2'd2);
    runFor(7, k, p);
    startT(2'd1);
    nCmp++;
    if (expired !== 1'b0 || busy !== 1'b1 || remaining !== 4'd5) begin
      nBad++;
      $display("FAIL terminal_start: got exp=%b busy=%b rem=%0d want 0/1/5",
               expired, busy, remaining);
    end
    runFor(24, k, p);
    nCmp++;
    if (k != 20 || p != 1) begin
      nBad++;
      $display("FAIL terminal_next: got at=%0d pulses=%0d want at=20 pulses=1", k, p);
    end
  endtask

  task automatic test_same_cycle_prog();
    int k, p;
    prog_sync = 1'b1; prog_sel = 2'd0; prog_value = 4'd1;
    startT(2'd0);
    nCmp++;
    if (remaining !== 4'd6) begin
      nBad++; $display("FAIL same_old: got %0d want 6", remaining);
    end
    runFor(28, k, p);
    nCmp++;
    if (k != 24 || p != 1) begin
      nBad++;
      $display("FAIL same_old_lat: got at=%0d pulses=%0d want at=24 pulses=1", k, p);
    end
    startT(2'd0);
    nCmp++;
    if (remaining !== 4'd1) begin
      nBad++; $display("FAIL same_new: got %0d want 1", remaining);
    end
    runFor(8, k, p);
    nCmp++;
    if (k != 4 || p != 1) begin
      nBad++;
      $display("FAIL same_new_lat: got at=%0d pulses=%0d want at=4 pulses=1", k, p);
    end
  endtask

  task automatic test_reset_mid();
    int k, p;
    startT(2'd0);
    runFor(9, k, p);
    reset = 1'b1;
    step();
    nCmp++;
    if (busy !== 1'b0 || remaining !== 4'd0 || expired !== 1'b0) begin
      nBad++;
      $display("FAIL mid_reset: got busy=%b rem=%0d exp=%b want 0/0/0",
               busy, remaining, expired);
    end
    runFor(30, k, p);
    nCmp++;
    if (p != 0) begin
      nBad++; $display("FAIL mid_reset_pulse: got %0d pulses want 0", p);
    end
    startT(2'd0);
    nCmp++;
    if (remaining !== 4'd6) begin
      nBad++; $display("FAIL default_base: got %0d want 6", remaining);
    end
    startT(2'd1);
    nCmp++;
    if (remaining !== 4'd3) begin
      nBad++; $display("FAIL default_ext: got %0d want 3", remaining);
    end
    startT(2'd2);
    nCmp++;
    if (remaining !== 4'd2) begin
      nBad++; $display("FAIL default_yel: got %0d want 2", remaining);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 59) == 0);
      start_timer = ($urandom_range(0, 9) == 0);
      time_param  = 2'($urandom_range(0, 3));
      prog_sync   = ($urandom_range(0, 5) == 0);
      prog_sel    = 2'($urandom_range(0, 3));
      prog_value  = 4'($urandom_range(0, 4));
      step();
      nCmp++;
      if (busy !== mRun) begin
        nBad++; $display("FAIL rnd_busy @%0d: got %b want %b", i, busy, mRun);
      end
      nCmp++;
      if (remaining !== 4'(mRem())) begin
        nBad++;
        $display("FAIL rnd_remaining @%0d: got %0d want %0d", i, remaining, mRem());
      end
      nCmp++;
      if (expired !== mExp) begin
        nBad++; $display("FAIL rnd_expired @%0d: got %b want %b", i, expired, mExp);
      end
      nCmp++;
      if (tick !== mTick()) begin
        nBad++; $display("FAIL rnd_tick @%0d: got %b want %b", i, tick, mTick());
      end
    end
  endtask

  initial begin
    test_reset();
    test_base();
    test_zero();
    test_prog_ext();
    test_restart();
    test_terminal_start();
    test_same_cycle_prog();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
